// File: rtl/mlp_pkg.sv
// Shared constants for the sequential MLP classifier: default widths, FSM states,
// and the trained layer weights and biases.
package mlp_pkg;

    localparam int N_IN   = 9;
    localparam int IN_W   = 4;
    localparam int N_HID  = 3;
    localparam int W_W    = 8;
    localparam int HID_W  = 13;
    localparam int ACC0_W = 14;
    localparam int ACC1_W = 22;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_L0   = 2'd1,
        ST_L1   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic signed [W_W-1:0] W0 [N_HID][N_IN] = '{
        '{-8'sd30, -8'sd13,  8'sd3,  -8'sd8,   8'sd7,  8'sd7,  8'sd40,  8'sd10,  8'sd38},
        '{ 8'sd33,  8'sd68,  8'sd79,  8'sd58, -8'sd17,  8'sd40, 8'sd42,  8'sd6,  -8'sd20},
        '{ 8'sd50,  8'sd27, -8'sd7,  -8'sd13,  8'sd30,  8'sd74, 8'sd1,  -8'sd20,  8'sd12}
    };

    // Layer-0 biases packed as 32-bit signed words, neuron h at bits [h*32 +: 32].
    localparam logic [N_HID*32-1:0] B0 = {-32'sd441, -32'sd362, 32'sd662};

    localparam logic signed [W_W-1:0] W1 [N_HID] = '{-8'sd18, 8'sd86, 8'sd61};
    localparam int B1 = -32'sd110178;

endpackage

// File: rtl/mlp_relu_sat.sv
// ReLU with optional unsigned saturation to OUT_BITS; shared by hidden and output neurons.
module mlp_relu_sat #(
    parameter int IN_BITS  = 14,
    parameter int OUT_BITS = 13,
    parameter bit SAT      = 1'b1
) (
    input  logic signed [IN_BITS-1:0]  din_i,
    output logic        [OUT_BITS-1:0] dout_o
);
    localparam int CW = (IN_BITS > OUT_BITS + 1) ? IN_BITS : OUT_BITS + 1;

    logic signed [CW-1:0] din_ext_s;
    logic signed [CW-1:0] max_s;

    // Clamp negatives to zero and, when enabled, large positives to all-ones.
    always_comb begin
        din_ext_s = CW'(din_i);
        max_s     = $signed(CW'({OUT_BITS{1'b1}}));
        if (din_ext_s[CW-1]) begin
            dout_o = '0;
        end else if (SAT && (din_ext_s > max_s)) begin
            dout_o = '1;
        end else begin
            dout_o = din_ext_s[OUT_BITS-1:0];
        end
    end

endmodule

// File: rtl/seq_mlp_classifier.sv
// Two-layer MLP classifier evaluated with one shared signed MAC, one product per cycle,
// behind valid/ready handshakes on the feature input and the result output.
module seq_mlp_classifier
    import mlp_pkg::*;
#(
    parameter int                    HID_BITS  = HID_W,
    parameter int                    ACC0_BITS = ACC0_W,
    parameter int                    ACC1_BITS = ACC1_W,
    parameter logic [N_HID*32-1:0]   B0_P      = B0,
    parameter int                    B1_P      = B1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*IN_W-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC1_BITS-2:0]   out_value,
    output logic                   out_class
);
    localparam int F_W    = $clog2(N_IN);
    localparam int H_W    = $clog2(N_HID);
    localparam int OP_W   = HID_BITS + 1;
    localparam int PROD_W = OP_W + W_W;

    state_t                      state_q;
    logic [F_W-1:0]              f_q;
    logic [H_W-1:0]              h_q;
    logic [N_IN*IN_W-1:0]        x_q;
    logic signed [ACC0_BITS-1:0] acc0_q;
    logic signed [ACC1_BITS-1:0] acc1_q;
    logic [HID_BITS-1:0]         hid_q [N_HID];
    logic                        in_ready_q;
    logic                        out_valid_q;
    logic                        out_class_q;
    logic [ACC1_BITS-2:0]        out_value_q;

    logic signed [OP_W-1:0]      mac_a_s;
    logic signed [W_W-1:0]       mac_b_s;
    logic signed [PROD_W-1:0]    prod_s;
    logic signed [ACC0_BITS-1:0] sum0_s;
    logic signed [ACC1_BITS-1:0] sum1_s;
    logic [HID_BITS-1:0]         hid_s;
    logic [ACC1_BITS-2:0]        out_s;

    // Shared MAC: operands are zero-extended activations times signed weights.
    always_comb begin
        mac_a_s = '0;
        mac_b_s = '0;
        if (state_q == ST_L1) begin
            mac_a_s = $signed({1'b0, hid_q[h_q]});
            mac_b_s = W1[h_q];
        end else begin
            mac_a_s = $signed(OP_W'(x_q[f_q*IN_W +: IN_W]));
            mac_b_s = W0[h_q][f_q];
        end
        prod_s = PROD_W'(mac_a_s) * PROD_W'(mac_b_s);
        sum0_s = ((f_q == '0) ? ACC0_BITS'($signed(B0_P[h_q*32 +: 32])) : acc0_q)
                 + ACC0_BITS'(prod_s);
        sum1_s = ((h_q == '0) ? ACC1_BITS'(B1_P) : acc1_q) + ACC1_BITS'(prod_s);
    end

    mlp_relu_sat #(
        .IN_BITS  (ACC0_BITS),
        .OUT_BITS (HID_BITS),
        .SAT      (1'b1)
    ) u_relu_hid (
        .din_i  (sum0_s),
        .dout_o (hid_s)
    );

    mlp_relu_sat #(
        .IN_BITS  (ACC1_BITS),
        .OUT_BITS (ACC1_BITS - 1),
        .SAT      (1'b0)
    ) u_relu_out (
        .din_i  (sum1_s),
        .dout_o (out_s)
    );

    // Sequencer: accept, layer-0 MACs, layer-1 MACs, hold result until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            f_q         <= '0;
            h_q         <= '0;
            x_q         <= '0;
            acc0_q      <= '0;
            acc1_q      <= '0;
            for (int i = 0; i < N_HID; i++) begin
                hid_q[i] <= '0;
            end
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_class_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        x_q        <= in_data;
                        f_q        <= '0;
                        h_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_L0;
                    end
                end
                ST_L0: begin
                    acc0_q <= sum0_s;
                    if (f_q == F_W'(N_IN - 1)) begin
                        hid_q[h_q] <= hid_s;
                        f_q        <= '0;
                        if (h_q == H_W'(N_HID - 1)) begin
                            h_q     <= '0;
                            state_q <= ST_L1;
                        end else begin
                            h_q <= h_q + 1'b1;
                        end
                    end else begin
                        f_q <= f_q + 1'b1;
                    end
                end
                ST_L1: begin
                    acc1_q <= sum1_s;
                    if (h_q == H_W'(N_HID - 1)) begin
                        out_value_q <= out_s;
                        out_class_q <= |out_s;
                        out_valid_q <= 1'b1;
                        h_q         <= '0;
                        state_q     <= ST_DONE;
                    end else begin
                        h_q <= h_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_value = out_value_q;
    assign out_class = out_class_q;

endmodule

// File: tb/tb_seq_mlp_classifier.sv
// Directed and model-based checks of the sequential MLP classifier, including a
// second instance with a boosted neuron-0 bias to exercise hidden saturation.
module tb_seq_mlp_classifier;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [35:0] in_data;
    logic        out_ready;
    logic        in_ready,  out_valid,  out_class;
    logic [20:0] out_value;
    logic        in_ready2, out_valid2, out_class2;
    logic [20:0] out_value2;

    int checks   = 0;
    int failures = 0;

    localparam logic [35:0] ALL0  = 36'h0;
    localparam logic [35:0] ALL15 = {9{4'hF}};
    localparam logic [35:0] ALL10 = {9{4'hA}};
    localparam logic [35:0] ALL5  = {9{4'h5}};

    localparam int W0T [3][9] = '{
        '{-30, -13,  3,  -8,   7,  7, 40,  10,  38},
        '{ 33,  68, 79,  58, -17, 40, 42,   6, -20},
        '{ 50,  27, -7, -13,  30, 74,  1, -20,  12}
    };
    localparam int B0T [3] = '{662, -362, -441};
    localparam int W1T [3] = '{-18, 86, 61};
    localparam int B1T     = -110178;

    always #5 clk = ~clk;

    seq_mlp_classifier dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_class (out_class)
    );

    seq_mlp_classifier #(
        .ACC0_BITS (16),
        .B0_P      ({-32'sd441, -32'sd362, 32'sd8000})
    ) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .in_data   (in_data),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .out_value (out_value2),
        .out_class (out_class2)
    );

    // Combinational reference: full dot products, ReLU with clamp at 8191, ReLU output.
    function automatic int golden(input logic [35:0] d);
        int hsum;
        int hid;
        int acc;
        acc = B1T;
        for (int h = 0; h < 3; h++) begin
            hsum = B0T[h];
            for (int f = 0; f < 9; f++) begin
                hsum += int'(d[f*4 +: 4]) * W0T[h][f];
            end
            hid = (hsum < 0) ? 0 : ((hsum > 8191) ? 8191 : hsum);
            acc += hid * W1T[h];
        end
        return (acc < 0) ? 0 : acc;
    endfunction

    // Waits for in_ready, presents one vector, returns cycles until out_valid.
    task automatic send_and_wait(input logic [35:0] d, output int lat, output bit to);
        int n;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        to = (out_valid !== 1'b1);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_value !== 21'd0) begin failures++; $display("FAIL reset_out_value: got %0d expected 0", out_value); end
        checks++; if (out_class !== 1'b0) begin failures++; $display("FAIL reset_out_class: got %b expected 0", out_class); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_zero();
        int lat;
        bit to;
        send_and_wait(ALL0, lat, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL zero_timeout: got %b expected 0", to); end
        checks++; if (lat !== 31) begin failures++; $display("FAIL zero_latency: got %0d expected 31", lat); end
        checks++; if (out_value !== 21'd0) begin failures++; $display("FAIL zero_value: got %0d expected 0", out_value); end
        checks++; if (out_class !== 1'b0) begin failures++; $display("FAIL zero_class: got %b expected 0", out_class); end
        checks++; if (dut.hid_q[0] !== 13'd662) begin failures++; $display("FAIL zero_hid0: got %0d expected 662", dut.hid_q[0]); end
        checks++; if (dut.hid_q[1] !== 13'd0) begin failures++; $display("FAIL zero_hid1: got %0d expected 0", dut.hid_q[1]); end
        checks++; if (dut.hid_q[2] !== 13'd0) begin failures++; $display("FAIL zero_hid2: got %0d expected 0", dut.hid_q[2]); end
    endtask

    task automatic test_all_max();
        int lat;
        bit to;
        send_and_wait(ALL15, lat, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL max_timeout: got %b expected 0", to); end
        checks++; if (out_value !== 21'd319013) begin failures++; $display("FAIL max_value: got %0d expected 319013", out_value); end
        checks++; if (out_class !== 1'b1) begin failures++; $display("FAIL max_class: got %b expected 1", out_class); end
        checks++; if (dut.hid_q[0] !== 13'd1472) begin failures++; $display("FAIL max_hid0: got %0d expected 1472", dut.hid_q[0]); end
        checks++; if (dut.hid_q[1] !== 13'd3973) begin failures++; $display("FAIL max_hid1: got %0d expected 3973", dut.hid_q[1]); end
        checks++; if (dut.hid_q[2] !== 13'd1869) begin failures++; $display("FAIL max_hid2: got %0d expected 1869", dut.hid_q[2]); end
    endtask

    task automatic test_directed();
        logic [35:0] vec [2];
        int          exp_v [2];
        int lat;
        bit to;
        vec[0] = ALL10; exp_v[0] = 152633;
        vec[1] = ALL5;  exp_v[1] = 0;
        for (int k = 0; k < 2; k++) begin
            send_and_wait(vec[k], lat, to);
            checks++; if (to !== 1'b0) begin failures++; $display("FAIL directed_timeout[%0d]: got %b expected 0", k, to); end
            checks++; if (out_value !== 21'(exp_v[k])) begin failures++; $display("FAIL directed_value[%0d]: got %0d expected %0d", k, out_value, exp_v[k]); end
            checks++; if (out_class !== (exp_v[k] != 0)) begin failures++; $display("FAIL directed_class[%0d]: got %b expected %b", k, out_class, exp_v[k] != 0); end
        end
    endtask

    task automatic test_single_feature();
        logic [35:0] d;
        int lat;
        int g;
        bit to;
        for (int i = 0; i < 9; i++) begin
            d = '0;
            d[i*4 +: 4] = 4'hF;
            g = golden(d);
            send_and_wait(d, lat, to);
            checks++; if (to !== 1'b0) begin failures++; $display("FAIL single_timeout[%0d]: got %b expected 0", i, to); end
            checks++; if (out_value !== 21'(g)) begin failures++; $display("FAIL single_value[%0d]: got %0d expected %0d", i, out_value, g); end
            checks++; if (out_class !== (g != 0)) begin failures++; $display("FAIL single_class[%0d]: got %b expected %b", i, out_class, g != 0); end
        end
    endtask

    task automatic test_saturation();
        int lat;
        bit to;
        send_and_wait(ALL15, lat, to);
        checks++; if (out_valid2 !== 1'b1) begin failures++; $display("FAIL sat_valid: got %b expected 1", out_valid2); end
        checks++; if (dut_sat.hid_q[0] !== 13'd8191) begin failures++; $display("FAIL sat_hid0: got %0d expected 8191", dut_sat.hid_q[0]); end
        checks++; if (dut_sat.hid_q[1] !== 13'd3973) begin failures++; $display("FAIL sat_hid1: got %0d expected 3973", dut_sat.hid_q[1]); end
        checks++; if (out_value2 !== 21'd198071) begin failures++; $display("FAIL sat_value: got %0d expected 198071", out_value2); end
        checks++; if (out_class2 !== 1'b1) begin failures++; $display("FAIL sat_class: got %b expected 1", out_class2); end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        out_ready = 1'b0;
        send_and_wait(ALL15, lat, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL bp_timeout: got %b expected 0", to); end
        in_valid = 1'b1;
        in_data  = ALL10;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", k, out_valid); end
            checks++; if (out_value !== 21'd319013) begin failures++; $display("FAIL bp_hold_value[%0d]: got %0d expected 319013", k, out_value); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", k, in_ready); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 31) begin failures++; $display("FAIL bp_next_latency: got %0d expected 31", lat); end
        checks++; if (out_value !== 21'd152633) begin failures++; $display("FAIL bp_next_value: got %0d expected 152633", out_value); end
    endtask

    task automatic test_back_to_back();
        int a0;
        int a1;
        int n;
        a0 = -1;
        a1 = -1;
        in_valid = 1'b1;
        in_data  = ALL15;
        for (int k = 0; k < 100 && a1 < 0; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                if (a0 < 0) a0 = k;
                else        a1 = k;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (a1 - a0 !== 32) begin failures++; $display("FAIL b2b_period: got %0d expected 32", a1 - a0); end
        checks++; if (out_value !== 21'd319013) begin failures++; $display("FAIL b2b_value: got %0d expected 319013", out_value); end
    endtask

    task automatic test_reset_midop();
        int lat;
        int n;
        bit to;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        in_data  = ALL15;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready: got %b expected 0", in_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_release: got %b expected 1", in_ready); end
        send_and_wait(ALL10, lat, to);
        checks++; if (lat !== 31) begin failures++; $display("FAIL midrst_latency: got %0d expected 31", lat); end
        checks++; if (out_value !== 21'd152633) begin failures++; $display("FAIL midrst_value: got %0d expected 152633", out_value); end
        checks++; if (dut.hid_q[1] !== 13'd2528) begin failures++; $display("FAIL midrst_hid1: got %0d expected 2528", dut.hid_q[1]); end
    endtask

    task automatic test_random();
        logic [35:0] d;
        int lat;
        int g;
        bit to;
        for (int k = 0; k < 500; k++) begin
            d = {4'($urandom), 32'($urandom)};
            g = golden(d);
            send_and_wait(d, lat, to);
            checks++; if (to !== 1'b0) begin failures++; $display("FAIL rand_timeout[%0d]: got %b expected 0", k, to); end
            checks++; if (out_value !== 21'(g)) begin failures++; $display("FAIL rand_value[%0d]: data %h got %0d expected %0d", k, d, out_value, g); end
            checks++; if (out_class !== (g != 0)) begin failures++; $display("FAIL rand_class[%0d]: got %b expected %b", k, out_class, g != 0); end
        end
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero();
        test_all_max();
        test_directed();
        test_single_feature();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
